// File: rtl/prbs_sync_checker_if.sv
// prbs_sync_checker_if: bit-stream input and statistics output bundle for the PRBS checker.
interface prbs_sync_checker_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             clear;
  logic             data_in;
  logic             data_in_valid;
  logic             locked;
  logic [CNT_W-1:0] total_bits;
  logic [CNT_W-1:0] total_bit_errors;
  logic [CNT_W-1:0] window_errors;
  logic             window_done;
  logic [CNT_W-1:0] lock_loss_count;
  modport master (
    output en, clear, data_in, data_in_valid,
    input  locked, total_bits, total_bit_errors, window_errors, window_done, lock_loss_count
  );
  modport slave (
    input  en, clear, data_in, data_in_valid,
    output locked, total_bits, total_bit_errors, window_errors, window_done, lock_loss_count
  );
endinterface

// File: rtl/prbs_sync_checker.sv
// prbs_sync_checker: self-synchronising PRBS checker with lock tracking, error counting and windowed BER.
module prbs_sync_checker #(
  parameter int PRBS_ORDER    = 31,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_ERRORS = 8,
  parameter int UNLOCK_WINDOW = 64,
  parameter int WINDOW_BITS   = 1024,
  parameter int CNT_W         = 32
) (
  input logic clk,
  input logic rst,
  prbs_sync_checker_if.slave bus
);
  localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                       (PRBS_ORDER == 9)  ? 5  :
                       (PRBS_ORDER == 15) ? 14 :
                       (PRBS_ORDER == 23) ? 18 :
                       (PRBS_ORDER == 31) ? 28 : 1;
  if (!(PRBS_ORDER inside {7, 9, 15, 23, 31})) begin : g_bad_order
    $error("prbs_sync_checker: unsupported PRBS_ORDER %0d", PRBS_ORDER);
  end
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ORDER_C = CNT_W'(PRBS_ORDER);
  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UERR_C  = CNT_W'(UNLOCK_ERRORS);
  localparam logic [CNT_W-1:0] UWIN_C  = CNT_W'(UNLOCK_WINDOW);
  localparam logic [CNT_W-1:0] WBITS_C = CNT_W'(WINDOW_BITS);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [PRBS_ORDER-1:0] h_q, h_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]      match_q, match_d;
  logic [CNT_W-1:0]      ub_q, ub_d;
  logic [CNT_W-1:0]      ue_q, ue_d;
  logic [CNT_W-1:0]      bb_q, bb_d;
  logic [CNT_W-1:0]      be_q, be_d;
  logic [CNT_W-1:0]      total_bits_q, total_bits_d;
  logic [CNT_W-1:0]      total_err_q, total_err_d;
  logic [CNT_W-1:0]      win_err_q, win_err_d;
  logic [CNT_W-1:0]      loss_q, loss_d;
  logic                  done_q, done_d;
  logic                  acc, clr, p, e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x, input logic inc);
    return (inc && x != '1) ? x + ONE : x;
  endfunction

  always_comb begin
    acc          = bus.en & bus.data_in_valid;
    clr          = bus.en & bus.clear;
    p            = h_q[PRBS_ORDER-1] ^ h_q[TAP-1];
    e            = bus.data_in ^ p;
    state_d      = state_q;
    h_d          = h_q;
    fill_d       = fill_q;
    match_d      = match_q;
    ub_d         = ub_q;
    ue_d         = ue_q;
    bb_d         = bb_q;
    be_d         = be_q;
    total_bits_d = total_bits_q;
    total_err_d  = total_err_q;
    win_err_d    = win_err_q;
    loss_d       = loss_q;
    done_d       = 1'b0;
    if (acc && state_q != LOCKED) begin
      h_d = {h_q[PRBS_ORDER-2:0], bus.data_in};
      if (state_q == SEED) begin
        fill_d = fill_q + ONE;
        if (fill_d == ORDER_C) begin
          state_d = VERIFY;
          match_d = '0;
        end
      end else if (e) begin
        state_d = SEED;
        fill_d  = '0;
      end else begin
        match_d = match_q + ONE;
        if (match_d == LOCK_C) begin
          state_d = LOCKED;
          ub_d    = '0;
          ue_d    = '0;
          bb_d    = '0;
          be_d    = '0;
        end
      end
    end
    // once locked, prediction free-runs so a single line error is counted once
    if (acc && state_q == LOCKED) begin
      h_d          = {h_q[PRBS_ORDER-2:0], p};
      total_bits_d = sat_inc(total_bits_q, 1'b1);
      total_err_d  = sat_inc(total_err_q, e);
      ub_d         = ub_q + ONE;
      ue_d         = ue_q + CNT_W'(e);
      bb_d         = bb_q + ONE;
      be_d         = be_q + CNT_W'(e);
      if (bb_d == WBITS_C) begin
        win_err_d = be_d;
        done_d    = 1'b1;
        bb_d      = '0;
        be_d      = '0;
      end
      if (ue_d == UERR_C) begin
        state_d = SEED;
        fill_d  = '0;
        loss_d  = sat_inc(loss_q, 1'b1);
        ub_d    = '0;
        ue_d    = '0;
        bb_d    = '0;
        be_d    = '0;
      end else if (ub_d == UWIN_C) begin
        ub_d = '0;
        ue_d = '0;
      end
    end
    if (clr) begin
      total_bits_d = '0;
      total_err_d  = '0;
      win_err_d    = '0;
      loss_d       = '0;
      bb_d         = '0;
      be_d         = '0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEED;
      h_q          <= '0;
      fill_q       <= '0;
      match_q      <= '0;
      ub_q         <= '0;
      ue_q         <= '0;
      bb_q         <= '0;
      be_q         <= '0;
      total_bits_q <= '0;
      total_err_q  <= '0;
      win_err_q    <= '0;
      loss_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      fill_q       <= fill_d;
      match_q      <= match_d;
      ub_q         <= ub_d;
      ue_q         <= ue_d;
      bb_q         <= bb_d;
      be_q         <= be_d;
      total_bits_q <= total_bits_d;
      total_err_q  <= total_err_d;
      win_err_q    <= win_err_d;
      loss_q       <= loss_d;
      done_q       <= done_d;
    end
  end

  assign bus.locked           = (state_q == LOCKED);
  assign bus.total_bits       = total_bits_q;
  assign bus.total_bit_errors = total_err_q;
  assign bus.window_errors    = win_err_q;
  assign bus.window_done      = done_q;
  assign bus.lock_loss_count  = loss_q;
endmodule

// File: tb/tb_prbs_sync_checker.sv
// tb_prbs_sync_checker: directed checks of lock, error counting, unlock, BER window, clear and reset.
module tb_prbs_sync_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic [30:0] g31;
  logic [6:0]  g7;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  prbs_sync_checker_if #(.CNT_W(32)) a_if ();
  prbs_sync_checker_if #(.CNT_W(32)) b_if ();

  prbs_sync_checker dut_a (.clk(clk), .rst(rst), .bus(a_if));
  prbs_sync_checker #(.PRBS_ORDER(7), .WINDOW_BITS(128)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic a_bit(input logic flip, input logic v);
    logic b;
    b = 1'b1;
    if (v) begin
      b   = g31[30] ^ g31[27];
      g31 = {g31[29:0], b};
    end
    a_if.data_in       = b ^ flip;
    a_if.data_in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic a_run(input int n);
    for (int i = 0; i < n; i++) a_bit(1'b0, 1'b1);
  endtask

  task automatic b_bit(input logic flip);
    logic b;
    b  = g7[6] ^ g7[5];
    g7 = {g7[5:0], b};
    b_if.data_in       = b ^ flip;
    b_if.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic b_run(input int n);
    for (int i = 0; i < n; i++) b_bit(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    g31 = 31'h1;
    g7  = 7'h1;
    a_if.en = 1'b0; a_if.clear = 1'b0; a_if.data_in = 1'b0; a_if.data_in_valid = 1'b0;
    b_if.en = 1'b0; b_if.clear = 1'b0; b_if.data_in = 1'b0; b_if.data_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", a_if.locked, 0);
    chk("rst_total_bits", a_if.total_bits, 0);
    chk("rst_total_errs", a_if.total_bit_errors, 0);
    chk("rst_win_errs", a_if.window_errors, 0);
    chk("rst_win_done", a_if.window_done, 0);
    chk("rst_loss", a_if.lock_loss_count, 0);
    chk("rst_b_locked", b_if.locked, 0);
    rst = 1'b0;
    a_if.en = 1'b1;
    a_run(46);
    chk("lock_after_46", a_if.locked, 0);
    a_run(1);
    chk("lock_after_47", a_if.locked, 1);
    chk("bits_at_lock", a_if.total_bits, 0);
    a_run(1000);
    chk("bits_1000", a_if.total_bits, 1000);
    chk("errs_1000", a_if.total_bit_errors, 0);
    a_run(23);
    chk("done_before_1024", a_if.window_done, 0);
    a_run(1);
    chk("done_at_1024", a_if.window_done, 1);
    chk("win_errs_1024", a_if.window_errors, 0);
    chk("bits_1024", a_if.total_bits, 1024);
    a_run(1);
    chk("done_pulse_end", a_if.window_done, 0);
    a_bit(1'b1, 1'b1);
    a_run(10);
    chk("single_flip_errs", a_if.total_bit_errors, 1);
    chk("single_flip_locked", a_if.locked, 1);
    chk("single_flip_loss", a_if.lock_loss_count, 0);
    chk("single_flip_bits", a_if.total_bits, 1036);
    a_if.clear = 1'b1;
    a_bit(1'b0, 1'b1);
    a_if.clear = 1'b0;
    chk("clear_bits", a_if.total_bits, 0);
    chk("clear_errs", a_if.total_bit_errors, 0);
    chk("clear_win_errs", a_if.window_errors, 0);
    chk("clear_loss", a_if.lock_loss_count, 0);
    chk("clear_locked", a_if.locked, 1);
    a_run(5);
    chk("bits_after_clear", a_if.total_bits, 5);
    a_run(46);
    for (int i = 0; i < 7; i++) a_bit(1'b1, 1'b1);
    chk("seven_flips_locked", a_if.locked, 1);
    chk("seven_flips_errs", a_if.total_bit_errors, 7);
    a_bit(1'b1, 1'b1);
    chk("eighth_flip_locked", a_if.locked, 0);
    chk("eighth_flip_loss", a_if.lock_loss_count, 1);
    chk("eighth_flip_errs", a_if.total_bit_errors, 8);
    chk("eighth_flip_bits", a_if.total_bits, 59);
    a_run(46);
    chk("relock_46", a_if.locked, 0);
    chk("relock_bits_frozen", a_if.total_bits, 59);
    a_run(1);
    chk("relock_47", a_if.locked, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked", a_if.locked, 0);
    chk("async_rst_bits", a_if.total_bits, 0);
    chk("async_rst_errs", a_if.total_bit_errors, 0);
    chk("async_rst_loss", a_if.lock_loss_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 46; i++) begin
      a_bit(1'b0, 1'b0);
      a_bit(1'b0, 1'b1);
    end
    a_bit(1'b0, 1'b0);
    chk("toggle_lock_46", a_if.locked, 0);
    a_bit(1'b0, 1'b1);
    chk("toggle_lock_47", a_if.locked, 1);
    for (int i = 0; i < 100; i++) begin
      a_bit(1'b0, 1'b0);
      a_bit(1'b0, 1'b1);
    end
    chk("toggle_bits", a_if.total_bits, 100);
    chk("toggle_errs", a_if.total_bit_errors, 0);
    a_if.en = 1'b0;
    a_if.data_in = ~a_if.data_in;
    a_if.data_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("en_low_bits", a_if.total_bits, 100);
    chk("en_low_locked", a_if.locked, 1);
    a_if.en = 1'b1;
    a_run(1);
    chk("en_resume_bits", a_if.total_bits, 101);
    chk("en_resume_errs", a_if.total_bit_errors, 0);
    a_if.en = 1'b0;
    b_if.en = 1'b1;
    b_run(22);
    chk("b_lock_22", b_if.locked, 0);
    b_run(1);
    chk("b_lock_23", b_if.locked, 1);
    b_run(9);
    b_bit(1'b1);
    b_run(19);
    b_bit(1'b1);
    b_run(19);
    b_bit(1'b1);
    b_run(77);
    chk("b_done_127", b_if.window_done, 0);
    b_run(1);
    chk("b_done_128", b_if.window_done, 1);
    chk("b_win_errs", b_if.window_errors, 3);
    chk("b_total_errs", b_if.total_bit_errors, 3);
    chk("b_total_bits", b_if.total_bits, 128);
    chk("b_locked", b_if.locked, 1);
    b_run(1);
    chk("b_done_129", b_if.window_done, 0);
    chk("b_win_errs_hold", b_if.window_errors, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
